// File: rtl/mmio_store_port_if.sv
// Store-snoop and output-port bundle for mmio_store_port.
// master: processor/consumer side; slave: the port itself.
interface mmio_store_port_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     MemWriteM;
  logic [31:0]              DataAdrM;
  logic [31:0]              WriteDataM;
  logic [31:0]              OutData;
  logic                     OutValid;
  logic                     OutReady;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Overflow;
  logic                     Done;
  logic [31:0]              DoneCode;

  modport master (
    output MemWriteM, DataAdrM, WriteDataM, OutReady,
    input  OutData, OutValid, Count, Overflow, Done, DoneCode
  );

  modport slave (
    input  MemWriteM, DataAdrM, WriteDataM, OutReady,
    output OutData, OutValid, Count, Overflow, Done, DoneCode
  );
endinterface

// File: rtl/mmio_store_port.sv
// MMIO output port: stores to PORT_ADDR feed a FIFO drained by valid/ready.
// Ports: clk, reset (async high), bus (slave: store snoop in, FIFO/done out).
module mmio_store_port #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] PORT_ADDR = 32'h0000_0080,
  parameter logic [31:0] DONE_ADDR = 32'h0000_0084
) (
  input  logic             clk,
  input  logic             reset,
  mmio_store_port_if.slave bus
);
  localparam int unsigned   AW   = $clog2(DEPTH);
  localparam int unsigned   CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          done;
  logic [31:0]   code;

  logic push;
  logic pop;
  logic full;
  logic wr;
  logic done_st;

  assign push    = bus.MemWriteM && (bus.DataAdrM == PORT_ADDR);
  assign done_st = bus.MemWriteM && (bus.DataAdrM == DONE_ADDR);
  assign full    = (cnt == FULL);
  assign pop     = (cnt != '0) && bus.OutReady;
  // A pop frees the slot the same edge, so full+pop still accepts.
  assign wr      = push && (!full || pop);

  // Storage needs no reset; it is only read while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= bus.WriteDataM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
      code <= '0;
    end else begin
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (wr && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !wr) cnt <= cnt - CW'(1);
      if (push && !wr) ovf <= 1'b1;
      if (done_st && !done) begin
        done <= 1'b1;
        code <= bus.WriteDataM;
      end
    end
  end

  assign bus.OutData  = mem[rp];
  assign bus.OutValid = (cnt != '0);
  assign bus.Count    = cnt;
  assign bus.Overflow = ovf;
  assign bus.Done     = done;
  assign bus.DoneCode = code;
endmodule

// File: tb/tb_mmio_store_port.sv
// Self-checking bench for mmio_store_port.
// Table vectors plus hand sequences for reset, wrap and random traffic.
module tb_mmio_store_port;
  logic clk = 1'b0;
  logic reset = 1'b1;

  mmio_store_port_if #(.DEPTH(4)) bus();

  mmio_store_port #(
    .DEPTH(4),
    .PORT_ADDR(32'h0000_0080),
    .DONE_ADDR(32'h0000_0084)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic        v;
    logic [31:0] d;
    int          c;
    logic        o;
    logic        dn;
    logic [31:0] code;
  } vec_t;

  vec_t tv[$];
  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] q[$];
  logic ovf_m;
  logic dn_m;
  logic [31:0] code_m;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] adr,
                     input logic [31:0] wd, input logic rdy,
                     input logic v, input logic [31:0] d, input int c,
                     input logic o, input logic dn,
                     input logic [31:0] code);
    vec_t t;
    t.we = we; t.adr = adr; t.wd = wd; t.rdy = rdy;
    t.v = v; t.d = d; t.c = c; t.o = o; t.dn = dn; t.code = code;
    tv.push_back(t);
  endtask

  task automatic drive(input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, input logic rdy);
    bus.MemWriteM  = we;
    bus.DataAdrM   = adr;
    bus.WriteDataM = wd;
    bus.OutReady   = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_count", 32'(bus.Count), 32'd0);
    chk("rst_valid", 32'(bus.OutValid), 32'd0);
    chk("rst_ovf", 32'(bus.Overflow), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_code", bus.DoneCode, 32'd0);

    add(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h80, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    add(0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 32'h80, 32'd1, 0, 1, 32'd1, 1, 0, 0, 0);
    add(1, 32'h80, 32'd2, 0, 1, 32'd1, 2, 0, 0, 0);
    add(1, 32'h80, 32'd3, 0, 1, 32'd1, 3, 0, 0, 0);
    add(1, 32'h80, 32'd4, 0, 1, 32'd1, 4, 0, 0, 0);
    add(1, 32'h80, 32'd5, 0, 1, 32'd1, 4, 1, 0, 0);
    add(0, 32'h0, 32'h0, 1, 1, 32'd2, 3, 1, 0, 0);
    add(0, 32'h0, 32'h0, 1, 1, 32'd3, 2, 1, 0, 0);
    add(0, 32'h0, 32'h0, 1, 1, 32'd4, 1, 1, 0, 0);
    add(0, 32'h0, 32'h0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 32'h7C, 32'hAA, 1, 0, 0, 0, 1, 0, 0);
    add(1, 32'h81, 32'hAB, 1, 0, 0, 0, 1, 0, 0);
    add(1, 32'h88, 32'hAC, 1, 0, 0, 0, 1, 0, 0);
    add(0, 32'h80, 32'hAD, 1, 0, 0, 0, 1, 0, 0);
    add(1, 32'h84, 32'd1, 1, 0, 0, 0, 1, 1, 32'd1);
    add(1, 32'h84, 32'd2, 1, 0, 0, 0, 1, 1, 32'd1);
    add(1, 32'h80, 32'h55, 1, 1, 32'h55, 1, 1, 1, 32'd1);
    add(0, 32'h0, 32'h0, 1, 0, 0, 0, 1, 1, 32'd1);

    foreach (tv[i]) begin
      drive(tv[i].we, tv[i].adr, tv[i].wd, tv[i].rdy);
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus.OutValid), 32'(tv[i].v));
      chk($sformatf("v%0d_count", i), 32'(bus.Count), 32'(tv[i].c));
      chk($sformatf("v%0d_ovf", i), 32'(bus.Overflow), 32'(tv[i].o));
      chk($sformatf("v%0d_done", i), 32'(bus.Done), 32'(tv[i].dn));
      chk($sformatf("v%0d_code", i), bus.DoneCode, tv[i].code);
      if (tv[i].v)
        chk($sformatf("v%0d_data", i), bus.OutData, tv[i].d);
    end

    // async reset with three words queued and sticky flags set
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80, 32'h300 + 32'(i), 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_count", 32'(bus.Count), 32'd3);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(bus.Count), 32'd0);
    chk("arst_valid", 32'(bus.OutValid), 32'd0);
    chk("arst_ovf", 32'(bus.Overflow), 32'd0);
    chk("arst_done", 32'(bus.Done), 32'd0);
    chk("arst_code", bus.DoneCode, 32'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 32'h80, 32'd7, 1'b0);
    step();
    chk("post_rst_data", bus.OutData, 32'd7);
    chk("post_rst_count", 32'(bus.Count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("post_rst_empty", 32'(bus.Count), 32'd0);

    // full FIFO with simultaneous push and pop across pointer wrap
    q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h80, 32'd10 + 32'(i), 1'b0);
      q.push_back(32'd10 + 32'(i));
      step();
    end
    chk("wrap_full", 32'(bus.Count), 32'd4);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h80, 32'd100 + 32'(i), 1'b1);
      void'(q.pop_front());
      q.push_back(32'd100 + 32'(i));
      step();
      chk($sformatf("wrap%0d_count", i), 32'(bus.Count), 32'd4);
      chk($sformatf("wrap%0d_ovf", i), 32'(bus.Overflow), 32'd0);
      chk($sformatf("wrap%0d_data", i), bus.OutData, q[0]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      chk($sformatf("wdrain%0d_data", i), bus.OutData, q[0]);
      void'(q.pop_front());
      step();
    end
    chk("wdrain_valid", 32'(bus.OutValid), 32'd0);

    // random traffic against a queue model
    ovf_m = 1'b0;
    dn_m = 1'b0;
    code_m = '0;
    for (int n = 0; n < 300; n++) begin
      logic we;
      logic rdy;
      logic [31:0] adr;
      logic [31:0] wd;
      logic popm;
      logic pshm;
      int sz;
      we = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 3))
        0, 1: adr = 32'h80;
        2: adr = 32'h84;
        default: adr = 32'h7C;
      endcase
      sz = q.size();
      popm = (sz != 0) && rdy;
      pshm = we && (adr == 32'h80);
      if (popm) void'(q.pop_front());
      if (pshm && (sz < 4 || popm)) q.push_back(wd);
      else if (pshm) ovf_m = 1'b1;
      if (we && adr == 32'h84 && !dn_m) begin
        dn_m = 1'b1;
        code_m = wd;
      end
      drive(we, adr, wd, rdy);
      step();
      chk($sformatf("r%0d_count", n), 32'(bus.Count), 32'(q.size()));
      chk($sformatf("r%0d_valid", n), 32'(bus.OutValid),
          32'(q.size() != 0));
      chk($sformatf("r%0d_ovf", n), 32'(bus.Overflow), 32'(ovf_m));
      chk($sformatf("r%0d_done", n), 32'(bus.Done), 32'(dn_m));
      chk($sformatf("r%0d_code", n), bus.DoneCode, code_m);
      if (q.size() != 0)
        chk($sformatf("r%0d_data", n), bus.OutData, q[0]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
